// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the decoder: FSM encoding,
// address-map defaults and MIPS instruction field helpers.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic [5:0] ins_opcode(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [15:0] ins_imm16(input logic [31:0] ins);
        return ins[15:0];
    endfunction

    function automatic logic [25:0] ins_target26(input logic [31:0] ins);
        return ins[25:0];
    endfunction

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (output im_req, output im_addr, input im_ack, input im_rdata);
    modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection (jr > jal > taken branch > pc+4) and
// legality check of the selected target against the instruction window.
module fetch_unit_npc_calc
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] pc,
    input  logic [25:0] ins_field,
    input  logic        is_jr,
    input  logic        is_jal,
    input  logic        is_branch,
    input  logic        cmp_eq,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        next_legal
);

    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * (IM_WORDS - 1));

    logic [31:0] branch_target;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + (sign_ext16(ins_field[15:0]) << 2);

    always_comb begin
        next_pc = pc_plus4;
        if (is_jr)
            next_pc = rs_data;
        else if (is_jal)
            next_pc = {pc[31:28], ins_field, 2'b00};
        else if (is_branch && cmp_eq)
            next_pc = branch_target;
    end

    assign next_legal = (next_pc[1:0] == 2'b00) &&
                        (next_pc >= IM_BASE) &&
                        (next_pc <= IM_LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per request and
// holds it for the decoder until the datapath accepts it.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | one-cycle landing state after reset
//   ST_FETCH | im_req high at pc, waiting for im_ack
//   ST_ISSUE | instruction register presented to decoder, awaiting ins_ready
//   ST_HALT  | illegal next PC seen; frozen until reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       mem,
    output logic [31:0]        ins,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               is_jr,
    input  logic               is_branch,
    input  logic               is_jal,
    input  logic               cmp_eq,
    input  logic [31:0]        rs_data,
    output logic               fault,
    output logic [31:0]        retired
);

    fetch_state_e state, state_nxt;

    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        fault_q;
    logic [31:0] retired_q;

    logic        ir_load;
    logic        pc_load;
    logic        fault_set;
    logic        retire;
    logic        req_c;
    logic        valid_c;

    logic [31:0] next_pc;
    logic        next_legal;

    fetch_unit_npc_calc #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_npc (
        .pc         (pc_q),
        .ins_field  (ir_q[25:0]),
        .is_jr      (is_jr),
        .is_jal     (is_jal),
        .is_branch  (is_branch),
        .cmp_eq     (cmp_eq),
        .rs_data    (rs_data),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .next_legal (next_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        fault_set = 1'b0;
        retire    = 1'b0;
        req_c     = 1'b0;
        valid_c   = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                req_c = 1'b1;
                if (mem.im_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                valid_c = 1'b1;
                if (ins_ready) begin
                    retire = 1'b1;
                    if (next_legal) begin
                        pc_load   = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        fault_set = 1'b1;
                        state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Acks arriving outside FETCH never reach ir_load, so stale data is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            if (ir_load)
                ir_q <= mem.im_rdata;
            if (pc_load)
                pc_q <= next_pc;
            if (fault_set)
                fault_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + 32'd1;
        end
    end

    assign mem.im_req  = req_c;
    assign mem.im_addr = pc_q;
    assign ins_valid   = valid_c;
    assign ins         = valid_c ? ir_q : 32'h0;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of instructions with expected
// next PC, plus hand sequences for faults, reset mid-transaction and wrap.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        is_jr = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        cmp_eq = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic        fault;
    logic [31:0] retired;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (bus),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .is_jr     (is_jr),
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .cmp_eq    (cmp_eq),
        .rs_data   (rs_data),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        jr, br, jal, eq;
        logic [31:0] rs;
        int          lat;
        int          stall;
        logic [31:0] exp_npc;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    vec_t        vecs[13];
    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_pc;
    logic [31:0] model_ret;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check32({tag, "_im_req"},    32'(bus.im_req), 32'd0);
        check32({tag, "_im_addr"},   bus.im_addr, 32'h0000_3000);
        check32({tag, "_ins"},       ins, 32'h0);
        check32({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
        check32({tag, "_pc"},        pc, 32'h0000_3000);
        check32({tag, "_pc_plus4"},  pc_plus4, 32'h0000_3004);
        check32({tag, "_fault"},     32'(fault), 32'd0);
        check32({tag, "_retired"},   retired, 32'd0);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.im_ack  = 1'b0;
        bus.im_rdata = 32'h0;
        ins_ready   = 1'b0;
        {is_jr, is_branch, is_jal, cmp_eq} = 4'b0;
        sb.delete();
        tick();
        tick();
        check_reset_vals("rst");
        reset     = 1'b1;
        model_pc  = 32'h0000_3000;
        model_ret = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] instr, input int lat);
        int guard = 0;
        while (!bus.im_req && guard < 20) begin
            tick();
            guard++;
        end
        check32("fetch_req", 32'(bus.im_req), 32'd1);
        check32("fetch_addr", bus.im_addr, model_pc);
        check32("fetch_ins_nop", ins, 32'h0);
        for (int i = 0; i < lat; i++) begin
            bus.im_rdata = $urandom;
            tick();
            check32("wait_req", 32'(bus.im_req), 32'd1);
            check32("wait_pc", pc, model_pc);
            check32("wait_valid", 32'(ins_valid), 32'd0);
        end
        bus.im_ack   = 1'b1;
        bus.im_rdata = instr;
        sb.push_back('{pc: model_pc, ins: instr});
        tick();
        bus.im_ack   = 1'b0;
        bus.im_rdata = $urandom;
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        check32("issue_valid", 32'(ins_valid), 32'd1);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got no queued fetch expected one");
        end else begin
            e = sb.pop_front();
            check32("issue_ins", ins, e.ins);
            check32("issue_pc", pc, e.pc);
        end
        check32("issue_pc_plus4", pc_plus4, model_pc + 32'd4);
        is_jr = v.jr; is_branch = v.br; is_jal = v.jal; cmp_eq = v.eq; rs_data = v.rs;
        for (int i = 0; i < v.stall; i++) begin
            tick();
            check32("stall_valid", 32'(ins_valid), 32'd1);
            check32("stall_ins", ins, v.instr);
            check32("stall_pc", pc, model_pc);
            check32("stall_retired", retired, model_ret);
        end
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        {is_jr, is_branch, is_jal, cmp_eq} = 4'b0;
        model_ret = model_ret + 32'd1;
        check32("acc_retired", retired, model_ret);
        if (v.exp_fault) begin
            check32("halt_fault", 32'(fault), 32'd1);
            check32("halt_req", 32'(bus.im_req), 32'd0);
            check32("halt_valid", 32'(ins_valid), 32'd0);
            check32("halt_ins", ins, 32'h0);
            check32("halt_pc", pc, model_pc);
        end else begin
            model_pc = v.exp_npc;
            check32("next_pc", pc, v.exp_npc);
            check32("next_req", 32'(bus.im_req), 32'd1);
            check32("next_fault", 32'(fault), 32'd0);
        end
    endtask

    task automatic halt_hold(input int n);
        bus.im_ack   = 1'b1;
        bus.im_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < n; i++) begin
            tick();
            check32("hold_req", 32'(bus.im_req), 32'd0);
            check32("hold_pc", pc, model_pc);
            check32("hold_fault", 32'(fault), 32'd1);
            check32("hold_valid", 32'(ins_valid), 32'd0);
            check32("hold_retired", retired, model_ret);
        end
        bus.im_ack = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic jr, input logic br,
                                input logic jal, input logic eq, input logic [31:0] rs,
                                input int lat, input int stall, input logic [31:0] npc,
                                input logic flt);
        vec_t v;
        v.instr = instr; v.jr = jr; v.br = br; v.jal = jal; v.eq = eq; v.rs = rs;
        v.lat = lat; v.stall = stall; v.exp_npc = npc; v.exp_fault = flt;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bad[3];
        vec_t        v;

        //             instr         jr br jal eq rs            lat st next_pc        fault
        vecs[0]  = mk(32'h0000_0000, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_3004, 0);
        vecs[1]  = mk(32'h0000_0000, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_3008, 0);
        vecs[2]  = mk(32'h2401_0001, 0, 0, 0, 0, 32'h0,         3, 2, 32'h0000_300C, 0);
        vecs[3]  = mk(32'h2402_0002, 0, 0, 0, 0, 32'h0,         1, 0, 32'h0000_3010, 0);
        vecs[4]  = mk(32'h1000_FFFC, 0, 1, 0, 1, 32'h0,         0, 0, 32'h0000_3004, 0);
        vecs[5]  = mk(32'h03E0_0008, 1, 0, 0, 0, 32'h0000_3010, 0, 1, 32'h0000_3010, 0);
        vecs[6]  = mk(32'h1000_FFFC, 0, 1, 0, 0, 32'h0,         0, 0, 32'h0000_3014, 0);
        vecs[7]  = mk(32'h03E0_0008, 1, 0, 0, 0, 32'h0000_3010, 2, 0, 32'h0000_3010, 0);
        vecs[8]  = mk(32'h0C00_0C10, 0, 0, 1, 0, 32'h0,         0, 0, 32'h0000_3040, 0);
        vecs[9]  = mk(32'h0C00_0C10, 1, 1, 1, 1, 32'h0000_3000, 0, 0, 32'h0000_3000, 0);
        vecs[10] = mk(32'h0C00_0C10, 0, 1, 1, 1, 32'h0,         0, 0, 32'h0000_3040, 0);
        vecs[11] = mk(32'h03E0_0008, 1, 0, 0, 0, 32'h0000_6FFC, 0, 0, 32'h0000_6FFC, 0);
        vecs[12] = mk(32'h0000_0000, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0000_7000, 1);

        bus.im_ack   = 1'b0;
        bus.im_rdata = 32'h0;

        // Reset release: one IDLE cycle, then request at 0x3000.
        do_reset();
        tick();
        check32("first_req", 32'(bus.im_req), 32'd1);
        check32("first_addr", bus.im_addr, 32'h0000_3000);
        for (int i = 0; i < 13; i++) begin
            fetch(vecs[i].instr, vecs[i].lat);
            issue(vecs[i]);
        end
        halt_hold(4);

        // Illegal jr targets: misaligned, one past the top, one below the base.
        bad[0] = 32'h0000_3002;
        bad[1] = 32'h0000_7000;
        bad[2] = 32'h0000_2FFC;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            v = mk(32'h03E0_0008, 1, 0, 0, 0, bad[i], 0, 0, 32'h0, 1);
            fetch(v.instr, 0);
            issue(v);
            halt_hold(3);
        end

        // Reset during FETCH, then a late ack across reset release.
        do_reset();
        tick();
        tick();
        tick();
        check32("mid_fetch_req", 32'(bus.im_req), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_vals("async_fetch");
        bus.im_ack   = 1'b1;
        bus.im_rdata = 32'hDEAD_BEEF;
        tick();
        reset = 1'b1;
        tick();
        check32("late_ack_valid", 32'(ins_valid), 32'd0);
        check32("late_ack_ins", ins, 32'h0);
        check32("restart_addr", bus.im_addr, 32'h0000_3000);
        bus.im_ack = 1'b0;
        sb.delete();
        model_pc  = 32'h0000_3000;
        model_ret = 32'd0;
        fetch(32'h2403_0003, 1);
        check32("restart_ins", ins, 32'h2403_0003);
        // Reset while an instruction is being issued.
        reset = 1'b0;
        #1;
        check_reset_vals("async_issue");
        tick();

        // Retired counter wrap.
        do_reset();
        tick();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check32("preload_retired", retired, 32'hFFFF_FFFF);
        model_ret = 32'hFFFF_FFFF;
        v = mk(32'h0000_0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0000_3004, 0);
        fetch(v.instr, 0);
        issue(v);
        check32("wrap_retired", retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
